// File: rtl/pool2d_engine_pkg.sv
// Shared types and helpers for the 2x2 stride-2 pooling engine.
package pool_pkg;

  // FSM encoding kept as plain constants so older tools and netlists agree on values.
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_READ  = 2'd1;
  localparam state_t S_DRAIN = 2'd2;
  localparam state_t S_DONE  = 2'd3;

  localparam logic POOL_MAX = 1'b0;
  localparam logic POOL_AVG = 1'b1;

  // Address/counter width for a given depth; never narrower than one bit.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pool2d_engine_if.sv
// Control handshake plus source-read / destination-write ports of the pooling engine.
interface pool2d_engine_if #(
  parameter int DATA_W   = 12,
  parameter int IN_W     = 10,
  parameter int IN_H     = 10,
  parameter int CHANNELS = 1
) ();
  import pool_pkg::*;
  localparam int RD_AW = addr_w(CHANNELS * IN_W * IN_H);
  localparam int WR_AW = addr_w(CHANNELS * (IN_W / 2) * (IN_H / 2));

  logic              start;
  logic              mode;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [RD_AW-1:0]  rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic [WR_AW-1:0]  wr_addr;
  logic [DATA_W-1:0] wr_data;

  // Controller / memory side.
  modport master (output start, mode, rd_data,
                  input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data);
  // Engine side.
  modport slave  (input  start, mode, rd_data,
                  output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/pool2d_engine_acc.sv
// Tag delay line aligned to read data, plus the max / sum window reducer and write register.
module pool_window_acc
  import pool_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int DATA_W = 12,
  parameter int WR_AW  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode_i,
  input  logic              vld_i,
  input  logic              first_i,
  input  logic              last_i,
  input  logic [WR_AW-1:0]  addr_i,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              wr_en_o,
  output logic [WR_AW-1:0]  wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o
);
  localparam int TW = WR_AW + 2;

  logic [RD_LAT-1:0]         vld_pipe;
  logic [RD_LAT-1:0][TW-1:0] tag_pipe;
  logic                      vld_a, first_a, last_a;
  logic [WR_AW-1:0]          addr_a;
  logic [DATA_W+1:0]         acc_q, acc_d, din;

  assign vld_a                    = vld_pipe[RD_LAT-1];
  assign {first_a, last_a, addr_a} = tag_pipe[RD_LAT-1];

  // Delay {vld, first, last, addr} by RD_LAT so they line up with rd_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      vld_pipe[0] <= vld_i;
      tag_pipe[0] <= {first_i, last_i, addr_i};
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  // Next accumulator: restart on first beat, else running max or running sum (2 guard bits).
  always_comb begin
    din = {2'b00, rd_data_i};
    if (first_a)                acc_d = din;
    else if (mode_i == POOL_AVG) acc_d = acc_q + din;
    else                        acc_d = (din > acc_q) ? din : acc_q;
  end

  // Accumulator register, advanced only on aligned valid beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     acc_q <= '0;
    else if (vld_a) acc_q <= acc_d;
  end

  // One-cycle write on the last beat of each window; average divides by 4 with truncation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_o   <= 1'b0;
      wr_addr_o <= '0;
      wr_data_o <= '0;
    end else begin
      wr_en_o <= vld_a & last_a;
      if (vld_a && last_a) begin
        wr_addr_o <= addr_a;
        wr_data_o <= (mode_i == POOL_AVG) ? acc_d[DATA_W+1:2] : acc_d[DATA_W-1:0];
      end
    end
  end
endmodule

// File: rtl/pool2d_engine.sv
// 2x2 stride-2 max/average pooling engine: FSM, window counters and address generation.
module pool2d_engine
  import pool_pkg::*;
#(
  parameter int DATA_W   = 12,
  parameter int IN_W     = 10,
  parameter int IN_H     = 10,
  parameter int CHANNELS = 1,
  parameter int RD_LAT   = 1
) (
  input logic            clk,
  input logic            rst_n,
  pool2d_engine_if.slave bus
);
  localparam int OW    = IN_W / 2;
  localparam int OH    = IN_H / 2;
  localparam int RD_AW = addr_w(CHANNELS * IN_W * IN_H);
  localparam int WR_AW = addr_w(CHANNELS * OW * OH);
  localparam int CW    = addr_w(CHANNELS);
  localparam int RW    = addr_w(OH);
  localparam int XW    = addr_w(OW);
  localparam int DW    = addr_w(RD_LAT + 1);

  state_t           state_q, state_d;
  logic             mode_q, mode_d;
  logic [CW-1:0]    ch_q, ch_d;
  logic [RW-1:0]    orow_q, orow_d;
  logic [XW-1:0]    ocol_q, ocol_d;
  logic [1:0]       quad_q, quad_d;
  logic [WR_AW-1:0] widx_q, widx_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic             busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d;
  logic [RD_AW-1:0] rd_addr_q, rd_addr_d;
  logic             first_q, first_d, last_q, last_d;
  logic [WR_AW-1:0] tag_addr_q, tag_addr_d;
  logic             last_rd;
  int               row_n, col_n;

  // Next-state logic: counters step one read per cycle; address is derived from the next counters.
  always_comb begin
    state_d = state_q;  mode_d = mode_q;  busy_d = busy_q;  done_d = done_q;
    rd_en_d = rd_en_q;  ch_d   = ch_q;    orow_d = orow_q;  ocol_d = ocol_q;
    quad_d  = quad_q;   widx_d = widx_q;  dcnt_d = dcnt_q;
    last_rd = (quad_q == 2'd3) && (ocol_q == XW'(OW - 1)) &&
              (orow_q == RW'(OH - 1)) && (ch_q == CW'(CHANNELS - 1));
    case (state_q)
      S_IDLE: if (bus.start) begin
        state_d = S_READ; mode_d = bus.mode; busy_d = 1'b1; rd_en_d = 1'b1;
        ch_d = '0; orow_d = '0; ocol_d = '0; quad_d = '0; widx_d = '0;
      end
      S_READ: if (last_rd) begin
        state_d = S_DRAIN; rd_en_d = 1'b0; dcnt_d = '0;
      end else begin
        quad_d = quad_q + 2'd1;
        if (quad_q == 2'd3) begin
          widx_d = widx_q + WR_AW'(1);
          if (ocol_q == XW'(OW - 1)) begin
            ocol_d = '0;
            if (orow_q == RW'(OH - 1)) begin
              orow_d = '0;
              ch_d   = ch_q + CW'(1);
            end else orow_d = orow_q + RW'(1);
          end else ocol_d = ocol_q + XW'(1);
        end
      end
      S_DRAIN: if (dcnt_q == DW'(RD_LAT)) begin
        state_d = S_DONE; busy_d = 1'b0; done_d = 1'b1;
      end else dcnt_d = dcnt_q + DW'(1);
      S_DONE: begin
        state_d = S_IDLE; done_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    row_n      = 2 * int'(orow_d) + int'(quad_d[1]);
    col_n      = 2 * int'(ocol_d) + int'(quad_d[0]);
    rd_addr_d  = RD_AW'(int'(ch_d) * IN_W * IN_H + row_n * IN_W + col_n);
    first_d    = (quad_d == 2'd0);
    last_d     = (quad_d == 2'd3);
    tag_addr_d = widx_d;
  end

  // State, counters and registered read-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE; mode_q <= POOL_MAX; busy_q <= 1'b0; done_q <= 1'b0;
      rd_en_q <= 1'b0;   ch_q   <= '0;       orow_q <= '0;   ocol_q <= '0;
      quad_q  <= '0;     widx_q <= '0;       dcnt_q <= '0;   rd_addr_q <= '0;
      first_q <= 1'b0;   last_q <= 1'b0;     tag_addr_q <= '0;
    end else begin
      state_q <= state_d; mode_q <= mode_d; busy_q <= busy_d; done_q <= done_d;
      rd_en_q <= rd_en_d; ch_q   <= ch_d;   orow_q <= orow_d; ocol_q <= ocol_d;
      quad_q  <= quad_d;  widx_q <= widx_d; dcnt_q <= dcnt_d; rd_addr_q <= rd_addr_d;
      first_q <= first_d; last_q <= last_d; tag_addr_q <= tag_addr_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = rd_addr_q;

  pool_window_acc #(.RD_LAT(RD_LAT), .DATA_W(DATA_W), .WR_AW(WR_AW)) u_acc (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode_i    (mode_q),
    .vld_i     (rd_en_q),
    .first_i   (first_q),
    .last_i    (last_q),
    .addr_i    (tag_addr_q),
    .rd_data_i (bus.rd_data),
    .wr_en_o   (bus.wr_en),
    .wr_addr_o (bus.wr_addr),
    .wr_data_o (bus.wr_data)
  );
endmodule

// File: tb/tb_pool2d_engine.sv
// Scoreboard bench: four engine configurations, directed steps plus a randomized RD_LAT sweep.
module tb_pool2d_engine;
  localparam int NC = 4;
  localparam int CFG_W [NC] = '{10, 5, 6, 7};
  localparam int CFG_H [NC] = '{10, 5, 7, 4};
  localparam int CFG_C [NC] = '{1, 3, 2, 2};
  localparam int CFG_L [NC] = '{1, 3, 2, 4};

  typedef struct { int addr; int data; } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   compared = 0, mismatched = 0;
  int   pat = 0, seed = 0;

  logic        start_a [NC];
  logic        mode_a  [NC];
  logic        busy_a [NC], done_a [NC], rd_en_a [NC], wr_en_a [NC];
  logic [31:0] rd_addr_a [NC], wr_addr_a [NC], wr_data_a [NC];
  exp_t        q [NC][$];
  int          wr_cnt [NC], done_cnt [NC], done_cyc [NC], first_wr_cyc [NC];
  int          first_wd [NC], last_wd [NC], last_wa [NC], bad_rd [NC];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [11:0] data_of(input int g, input int a);
    int w, h, row, col;
    logic [31:0] x;
    w = CFG_W[g]; h = CFG_H[g];
    col = a % w; row = (a % (w * h)) / w;
    x = 32'(a) * 32'h9E3779B1 + 32'(seed);
    case (pat)
      0: return x[11:0] - (32'h9E3779B1 * 32'(a) + 32'(seed)) + 12'(a);
      1: case ({row[0], col[0]})
           2'b00:   return 12'd4;
           2'b01:   return 12'd5;
           2'b10:   return 12'd6;
           default: return 12'd8;
         endcase
      2: return 12'hFFF;
      default: return x[19:8];
    endcase
  endfunction

  // Reference model: expected write stream for one job.
  task automatic push_exp(input int g, input bit m);
    int w, h, c, ow, oh, idx, base, s, mx, v;
    exp_t e;
    w = CFG_W[g]; h = CFG_H[g]; c = CFG_C[g]; ow = w / 2; oh = h / 2; idx = 0;
    for (int ch = 0; ch < c; ch++)
      for (int orow = 0; orow < oh; orow++)
        for (int ocol = 0; ocol < ow; ocol++) begin
          base = ch * w * h + 2 * orow * w + 2 * ocol;
          s = 0; mx = 0;
          for (int j = 0; j < 4; j++) begin
            v = int'(data_of(g, base + (j / 2) * w + (j % 2)));
            s += v;
            if (v > mx) mx = v;
          end
          e.addr = idx++;
          e.data = m ? (s >> 2) : mx;
          q[g].push_back(e);
        end
  endtask

  for (genvar g = 0; g < NC; g++) begin : gi
    localparam int W = CFG_W[g], H = CFG_H[g], C = CFG_C[g], L = CFG_L[g];
    pool2d_engine_if #(.DATA_W(12), .IN_W(W), .IN_H(H), .CHANNELS(C)) bus ();
    logic [11:0] mp [L];

    assign bus.start = start_a[g];
    assign bus.mode  = mode_a[g];
    assign bus.rd_data = mp[L-1];
    assign busy_a[g] = bus.busy;   assign done_a[g]  = bus.done;
    assign rd_en_a[g] = bus.rd_en; assign wr_en_a[g] = bus.wr_en;
    assign rd_addr_a[g] = 32'(bus.rd_addr);
    assign wr_addr_a[g] = 32'(bus.wr_addr);
    assign wr_data_a[g] = 32'(bus.wr_data);

    pool2d_engine #(.DATA_W(12), .IN_W(W), .IN_H(H), .CHANNELS(C), .RD_LAT(L)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );

    always @(posedge clk) begin
      mp[0] <= (bus.rd_en === 1'b1) ? data_of(g, int'(bus.rd_addr)) : 12'hABC;
      for (int i = 1; i < L; i++) mp[i] <= mp[i-1];
    end

    always @(negedge clk) begin
      exp_t e;
      if (bus.wr_en === 1'b1) begin
        if (first_wr_cyc[g] < 0) begin
          first_wr_cyc[g] = cyc;
          first_wd[g] = int'(bus.wr_data);
        end
        last_wd[g] = int'(bus.wr_data);
        last_wa[g] = int'(bus.wr_addr);
        wr_cnt[g]++;
        if (q[g].size() == 0) chk("wr_unexpected", 0, 1);
        else begin
          e = q[g].pop_front();
          chk("wr_addr", 32'(bus.wr_addr), e.addr);
          chk("wr_data", 32'(bus.wr_data), e.data);
        end
      end
      if (bus.done === 1'b1) begin
        done_cnt[g]++;
        done_cyc[g] = cyc;
      end
      if (bus.rd_en === 1'b1)
        if ((int'(bus.rd_addr) % W) >= 2 * (W / 2) ||
            ((int'(bus.rd_addr) % (W * H)) / W) >= 2 * (H / 2)) bad_rd[g]++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic run(input int g, input bit m, input int p, input int s,
                     input int restart_at, input int abort_at, input bit b2b);
    int k, n, l, dc0, wc0;
    bit ended;
    n = CFG_C[g] * (CFG_W[g] / 2) * (CFG_H[g] / 2);
    l = CFG_L[g];
    tick();
    pat = p; seed = s;
    push_exp(g, m);
    dc0 = done_cnt[g]; wc0 = wr_cnt[g]; first_wr_cyc[g] = -1;
    start_a[g] = 1'b1; mode_a[g] = m; k = cyc + 1;
    tick();
    start_a[g] = 1'b0;
    chk("busy_on", busy_a[g], 1);
    chk("rd_en_on", rd_en_a[g], 1);
    chk("rd_addr_first", rd_addr_a[g], 0);
    ended = 0;
    for (int t = 0; t < 4 * n + l + 20 && !ended; t++) begin
      tick();
      if (restart_at > 0 && cyc == k + restart_at) begin
        start_a[g] = 1'b1; mode_a[g] = !m;
      end else start_a[g] = 1'b0;
      if (abort_at > 0 && cyc == k + abort_at) begin
        rst_n = 1'b0;
        q[g].delete();
        #1;
        chk("abort_busy", busy_a[g], 0);
        chk("abort_rd_en", rd_en_a[g], 0);
        chk("abort_wr_en", wr_en_a[g], 0);
        tick();
        rst_n = 1'b1;
        repeat (4 * n + l + 10) tick();
        chk("abort_no_done", done_cnt[g] - dc0, 0);
        mode_a[g] = m;
        return;
      end
      if (done_cnt[g] != dc0) begin
        ended = 1;
        chk("done_cyc", done_cyc[g], k + 4 * n + l + 1);
        chk("busy_fall", busy_a[g], 0);
        chk("first_wr_cyc", first_wr_cyc[g], k + 4 + l);
        chk("wr_count", wr_cnt[g] - wc0, n);
        chk("queue_empty", q[g].size(), 0);
        if (b2b) begin
          start_a[g] = 1'b1;
          tick();
          start_a[g] = 1'b0;
          tick();
          chk("b2b_ignored", {31'd0, busy_a[g] | rd_en_a[g]}, 0);
        end
      end
    end
    if (!ended) chk("done_timeout", done_cnt[g] - dc0, 1);
    repeat (8) tick();
    chk("one_done", done_cnt[g] - dc0, 1);
    mode_a[g] = m;
    start_a[g] = 1'b0;
  endtask

  initial begin
    for (int g = 0; g < NC; g++) begin
      start_a[g] = 1'b0; mode_a[g] = 1'b0;
      wr_cnt[g] = 0; done_cnt[g] = 0; done_cyc[g] = 0; first_wr_cyc[g] = -1;
      first_wd[g] = 0; last_wd[g] = 0; last_wa[g] = 0; bad_rd[g] = 0;
    end
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_busy", busy_a[0], 0);
    chk("rst_done", done_a[0], 0);
    chk("rst_rd_en", rd_en_a[0], 0);
    chk("rst_wr_en", wr_en_a[0], 0);
    chk("rst_rd_addr", rd_addr_a[0], 0);
    chk("rst_wr_addr", wr_addr_a[0], 0);
    chk("rst_wr_data", wr_data_a[0], 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Max over a ramp on the default 10x10 map.
    run(0, 1'b0, 0, 0, 0, 0, 1'b0);
    chk("ramp_first", first_wd[0], 11);
    chk("ramp_last", last_wd[0], 99);
    chk("ramp_last_addr", last_wa[0], 24);

    // Average of {4,5,6,8} and of saturated samples.
    run(0, 1'b1, 1, 0, 0, 0, 1'b0);
    chk("avg_4568", last_wd[0], 5);
    run(0, 1'b1, 2, 0, 0, 0, 1'b0);
    chk("avg_full", last_wd[0], 4095);

    // Odd 5x5 maps, 3 channels, latency 3.
    run(1, 1'b0, 0, 0, 0, 0, 1'b0);
    chk("c3_last_addr", last_wa[1], 11);
    chk("c3_bad_rd", bad_rd[1], 0);

    // Start and mode toggled mid-run, then a start while done is high.
    run(0, 1'b0, 3, 32'h1234, 10, 0, 1'b1);

    // Reset mid-run, then a clean run.
    run(0, 1'b0, 3, 32'h55, 0, 40, 1'b0);
    run(0, 1'b1, 3, 32'h77, 0, 0, 1'b0);

    // Random data over every configuration (RD_LAT 1..4) in both modes.
    for (int g = 0; g < NC; g++)
      for (int m = 0; m < 2; m++)
        run(g, m[0], 3, int'($urandom), 0, 0, 1'b0);
    chk("bad_rd_g2", bad_rd[2], 0);
    chk("bad_rd_g3", bad_rd[3], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
